acc_mem_feeder: RTL

//  Upstream controller for the accumulator core. On start it clears the core,

---
 rtl/acc_mem_feeder.sv | 123 ++++++++++++
 1 files changed

// File: rtl/acc_mem_feeder.sv
// Memory-to-accumulator feeder: clears the core, streams N words from a
// 1-cycle-latency memory as number/valid, drains, then captures the core sum.
module acc_mem_feeder #(
    parameter int unsigned IN_DATA_WIDTH = 8,
    parameter int unsigned AWIDTH        = 8,
    parameter int unsigned DWIDTH        = 16,
    parameter int unsigned DRAIN_CYC     = 2
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     start_i,
    input  logic [AWIDTH:0]          num_cnt_i,
    output logic                     mem_ce_o,
    output logic [AWIDTH-1:0]        mem_addr_o,
    input  logic [IN_DATA_WIDTH-1:0] mem_q_i,
    output logic                     core_run_o,
    output logic                     core_valid_o,
    output logic [IN_DATA_WIDTH-1:0] core_number_o,
    input  logic [DWIDTH-1:0]        core_result_i,
    output logic                     busy_o,
    output logic                     done_o,
    output logic [DWIDTH-1:0]        result_o
);

    localparam int unsigned WW = (DRAIN_CYC > 2) ? $clog2(DRAIN_CYC) : 1;

    typedef enum logic [2:0] {
        StIdle,
        StRun,
        StRead,
        StWait,
        StDone
    } state_e;

    state_e              state_q;
    logic [AWIDTH:0]     n_q;
    logic [AWIDTH:0]     rd_cnt_q;
    logic [WW-1:0]       wait_q;
    logic                mem_ce_q;
    logic [AWIDTH-1:0]   mem_addr_q;
    logic                core_run_q;
    logic                core_valid_q;
    logic                done_q;
    logic [DWIDTH-1:0]   result_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= StIdle;
            n_q          <= '0;
            rd_cnt_q     <= '0;
            wait_q       <= '0;
            mem_ce_q     <= 1'b0;
            mem_addr_q   <= '0;
            core_run_q   <= 1'b0;
            core_valid_q <= 1'b0;
            done_q       <= 1'b0;
            result_q     <= '0;
        end else begin
            core_run_q   <= 1'b0;
            done_q       <= 1'b0;
            core_valid_q <= mem_ce_q;
            unique case (state_q)
                StIdle: begin
                    if (start_i) begin
                        n_q        <= num_cnt_i;
                        core_run_q <= 1'b1;
                        state_q    <= StRun;
                    end
                end
                StRun: begin
                    if (n_q != '0) begin
                        mem_ce_q   <= 1'b1;
                        mem_addr_q <= '0;
                        rd_cnt_q   <= (AWIDTH + 1)'(1);
                        state_q    <= StRead;
                    end else begin
                        result_q <= '0;
                        done_q   <= 1'b1;
                        state_q  <= StDone;
                    end
                end
                StRead: begin
                    // rd_cnt_q is one wider than the address, so N = 2**AWIDTH stops cleanly.
                    if (rd_cnt_q == n_q) begin
                        mem_ce_q   <= 1'b0;
                        mem_addr_q <= '0;
                        wait_q     <= '0;
                        state_q    <= StWait;
                    end else begin
                        mem_addr_q <= rd_cnt_q[AWIDTH-1:0];
                        rd_cnt_q   <= rd_cnt_q + (AWIDTH + 1)'(1);
                    end
                end
                StWait: begin
                    if (wait_q == WW'(DRAIN_CYC - 1)) begin
                        result_q <= core_result_i;
                        done_q   <= 1'b1;
                        state_q  <= StDone;
                    end else begin
                        wait_q <= wait_q + WW'(1);
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign mem_ce_o      = mem_ce_q;
    assign mem_addr_o    = mem_addr_q;
    assign core_run_o    = core_run_q;
    assign core_valid_o  = core_valid_q;
    // Zero outside valid cycles so a free-running core accumulates nothing extra.
    assign core_number_o = core_valid_q ? mem_q_i : '0;
    assign busy_o        = (state_q != StIdle);
    assign done_o        = done_q;
    assign result_o      = result_q;

endmodule
